// File: rtl/int_adder_pipe_if.sv
// Issue-side and writeback-side handshake bundle for the pipelined integer adder.
// The issue/writeback logic takes master; the adder itself takes slave.
interface int_adder_pipe_if #(
   parameter int DATA_WIDTH = 32,
   parameter int IMM_WIDTH  = 12,
   parameter int TAG_WIDTH  = 5
);
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [2:0]            op;
   logic [DATA_WIDTH-1:0] src1;
   logic [DATA_WIDTH-1:0] src2;
   logic [IMM_WIDTH-1:0]  imm;
   logic [TAG_WIDTH-1:0]  tag_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] result;
   logic [TAG_WIDTH-1:0]  tag_out;
   logic                  flag_zero;
   logic                  flag_carry;
   logic                  flag_ovf;
   logic                  illegal;

   modport master (
      output flush, in_valid, op, src1, src2, imm, tag_in, out_ready,
      input  in_ready, out_valid, result, tag_out, flag_zero, flag_carry, flag_ovf, illegal
   );

   modport slave (
      input  flush, in_valid, op, src1, src2, imm, tag_in, out_ready,
      output in_ready, out_valid, result, tag_out, flag_zero, flag_carry, flag_ovf, illegal
   );
endinterface

// File: rtl/int_adder_pipe.sv
// Pipelined integer add/sub/set-less-than unit with tag, flags, back-pressure and flush.
// All arithmetic happens before stage 1; later stages only carry the packaged result.
module int_adder_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int IMM_WIDTH  = 12,
   parameter int STAGES     = 2,
   parameter int TAG_WIDTH  = 5
) (
   input logic             clk,
   input logic             reset,
   int_adder_pipe_if.slave bus
);
   typedef enum logic [2:0] {
      OP_ADD   = 3'b000,
      OP_SUB   = 3'b001,
      OP_ADDI  = 3'b010,
      OP_SLT   = 3'b011,
      OP_SLTU  = 3'b100,
      OP_SLTI  = 3'b101,
      OP_SLTIU = 3'b110,
      OP_RSVD  = 3'b111
   } op_e;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] result;
      logic [TAG_WIDTH-1:0]  tag;
      logic                  zero;
      logic                  carry;
      logic                  ovf;
      logic                  illegal;
   } stage_t;

   op_e                   op;
   logic [DATA_WIDTH-1:0] imm_ext;
   logic [DATA_WIDTH-1:0] operand_b;
   logic                  carry_in;
   logic [DATA_WIDTH:0]   sum;
   logic                  ovf;
   stage_t                computed;

   logic [STAGES-1:0]     valid_q;
   logic [STAGES-1:0]     slot_open;
   stage_t                pipe_q [STAGES];

   assign op      = op_e'(bus.op);
   assign imm_ext = {{(DATA_WIDTH-IMM_WIDTH){bus.imm[IMM_WIDTH-1]}}, bus.imm};

   // Subtract and compare share the adder by inverting B and injecting a carry.
   always_comb begin
      operand_b = bus.src2;
      carry_in  = 1'b0;
      case (op)
         OP_ADD: operand_b = bus.src2;
         OP_SUB, OP_SLT, OP_SLTU: begin
            operand_b = ~bus.src2;
            carry_in  = 1'b1;
         end
         OP_ADDI: operand_b = imm_ext;
         OP_SLTI, OP_SLTIU: begin
            operand_b = ~imm_ext;
            carry_in  = 1'b1;
         end
         default: operand_b = '0;
      endcase
   end

   assign sum = {1'b0, bus.src1} + {1'b0, operand_b} + {{DATA_WIDTH{1'b0}}, carry_in};
   assign ovf = (bus.src1[DATA_WIDTH-1] == operand_b[DATA_WIDTH-1])
              & (sum[DATA_WIDTH-1] != bus.src1[DATA_WIDTH-1]);

   always_comb begin
      computed         = '0;
      computed.tag     = bus.tag_in;
      computed.carry   = sum[DATA_WIDTH];
      computed.ovf     = ovf;
      computed.illegal = 1'b0;
      case (op)
         OP_SLT, OP_SLTI:   computed.result = {{(DATA_WIDTH-1){1'b0}}, sum[DATA_WIDTH-1] ^ ovf};
         OP_SLTU, OP_SLTIU: computed.result = {{(DATA_WIDTH-1){1'b0}}, ~sum[DATA_WIDTH]};
         OP_RSVD: begin
            computed.result  = '0;
            computed.carry   = 1'b0;
            computed.ovf     = 1'b0;
            computed.illegal = 1'b1;
         end
         default: computed.result = sum[DATA_WIDTH-1:0];
      endcase
      computed.zero = !computed.illegal && (computed.result == '0);
   end

   // A stage can take new contents if the output drains or any stage from it onward is empty;
   // evaluated in closed form so there is no ripple chain through the stages.
   always_comb begin
      slot_open = '0;
      for (int i = 0; i < STAGES; i++) begin
         slot_open[i] = bus.out_ready | (|(~valid_q >> i));
      end
   end

   assign bus.in_ready = !bus.flush & slot_open[0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            pipe_q[i] <= '0;
         end
      end else if (bus.flush) begin
         valid_q <= '0;
      end else begin
         if (slot_open[0]) begin
            valid_q[0] <= bus.in_valid;
            if (bus.in_valid) begin
               pipe_q[0] <= computed;
            end
         end
         for (int i = 1; i < STAGES; i++) begin
            if (slot_open[i]) begin
               valid_q[i] <= valid_q[i-1];
               if (valid_q[i-1]) begin
                  pipe_q[i] <= pipe_q[i-1];
               end
            end
         end
      end
   end

   assign bus.out_valid  = valid_q[STAGES-1];
   assign bus.result     = pipe_q[STAGES-1].result;
   assign bus.tag_out    = pipe_q[STAGES-1].tag;
   assign bus.flag_zero  = pipe_q[STAGES-1].zero;
   assign bus.flag_carry = pipe_q[STAGES-1].carry;
   assign bus.flag_ovf   = pipe_q[STAGES-1].ovf;
   assign bus.illegal    = pipe_q[STAGES-1].illegal;
endmodule

// File: tb/tb_int_adder_pipe.sv
// Directed self-checking bench for int_adder_pipe at DATA_WIDTH=32, STAGES=2.
module tb_int_adder_pipe;
   localparam int DW = 32;
   localparam int IW = 12;
   localparam int ST = 2;
   localparam int TW = 5;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_ADDI  = 3'b010;
   localparam logic [2:0] OP_SLT   = 3'b011;
   localparam logic [2:0] OP_SLTU  = 3'b100;
   localparam logic [2:0] OP_SLTI  = 3'b101;
   localparam logic [2:0] OP_SLTIU = 3'b110;
   localparam logic [2:0] OP_RSVD  = 3'b111;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   passed = 0;
   int   total = 0;

   int_adder_pipe_if #(.DATA_WIDTH(DW), .IMM_WIDTH(IW), .TAG_WIDTH(TW)) bus ();

   int_adder_pipe #(.DATA_WIDTH(DW), .IMM_WIDTH(IW), .STAGES(ST), .TAG_WIDTH(TW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one uop for exactly one clock edge, then drops in_valid.
   task automatic drive_uop(input logic [2:0] op, input logic [DW-1:0] s1, input logic [DW-1:0] s2,
                            input logic [IW-1:0] imm, input logic [TW-1:0] tag);
      bus.op = op; bus.src1 = s1; bus.src2 = s2; bus.imm = imm; bus.tag_in = tag;
      bus.in_valid = 1'b1;
      #1;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      total++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL rst_out_valid got %b want 0", bus.out_valid); else passed++;
      total++; if (bus.result !== 32'h0) $display("[TB] FAIL rst_result got %h want 0", bus.result); else passed++;
      total++; if (bus.tag_out !== 5'd0) $display("[TB] FAIL rst_tag got %0d want 0", bus.tag_out); else passed++;
      total++; if ({bus.flag_zero, bus.flag_carry, bus.flag_ovf, bus.illegal} !== 4'b0000)
         $display("[TB] FAIL rst_flags got %b want 0000", {bus.flag_zero, bus.flag_carry, bus.flag_ovf, bus.illegal}); else passed++;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      total++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL rst_in_ready got %b want 1", bus.in_ready); else passed++;
   endtask

   task automatic test_add_latency();
      bus.out_ready = 1'b1;
      bus.op = OP_ADD; bus.src1 = 32'h7FFF_FFFF; bus.src2 = 32'h1; bus.imm = '0; bus.tag_in = 5'd1;
      bus.in_valid = 1'b1;
      #1;
      total++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL add_in_ready got %b want 1", bus.in_ready); else passed++;
      tick();
      bus.in_valid = 1'b0;
      total++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL add_early_valid got %b want 0", bus.out_valid); else passed++;
      tick();
      total++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL add_latency got %b want 1", bus.out_valid); else passed++;
      total++; if (bus.result !== 32'h8000_0000) $display("[TB] FAIL add_result got %h want 80000000", bus.result); else passed++;
      total++; if ({bus.flag_ovf, bus.flag_carry, bus.flag_zero} !== 3'b100)
         $display("[TB] FAIL add_flags ovf/carry/zero got %b want 100", {bus.flag_ovf, bus.flag_carry, bus.flag_zero}); else passed++;
      total++; if (bus.tag_out !== 5'd1) $display("[TB] FAIL add_tag got %0d want 1", bus.tag_out); else passed++;
   endtask

   task automatic test_sub_addi();
      drive_uop(OP_SUB, 32'd5, 32'd5, '0, 5'd2);
      tick();
      total++; if (bus.result !== 32'd0) $display("[TB] FAIL sub_result got %h want 0", bus.result); else passed++;
      total++; if ({bus.flag_zero, bus.flag_carry, bus.flag_ovf} !== 3'b110)
         $display("[TB] FAIL sub_flags zero/carry/ovf got %b want 110", {bus.flag_zero, bus.flag_carry, bus.flag_ovf}); else passed++;
      drive_uop(OP_ADDI, 32'd10, 32'h1234, 12'hFFF, 5'd3);
      tick();
      total++; if (bus.result !== 32'd9) $display("[TB] FAIL addi_result got %h want 9", bus.result); else passed++;
      total++; if ({bus.flag_carry, bus.flag_zero, bus.flag_ovf} !== 3'b100)
         $display("[TB] FAIL addi_flags carry/zero/ovf got %b want 100", {bus.flag_carry, bus.flag_zero, bus.flag_ovf}); else passed++;
   endtask

   task automatic test_compare();
      drive_uop(OP_SLT, 32'hFFFF_FFFF, 32'd1, '0, 5'd4);
      tick();
      total++; if (bus.result !== 32'd1) $display("[TB] FAIL slt_result got %h want 1", bus.result); else passed++;
      drive_uop(OP_SLTU, 32'hFFFF_FFFF, 32'd1, '0, 5'd5);
      tick();
      total++; if (bus.result !== 32'd0) $display("[TB] FAIL sltu_result got %h want 0", bus.result); else passed++;
      total++; if (bus.flag_zero !== 1'b1) $display("[TB] FAIL sltu_zero got %b want 1", bus.flag_zero); else passed++;
      drive_uop(OP_SLTIU, 32'd5, 32'd0, 12'hFFF, 5'd6);
      tick();
      total++; if (bus.result !== 32'd1) $display("[TB] FAIL sltiu_result got %h want 1", bus.result); else passed++;
      total++; if (bus.flag_carry !== 1'b0) $display("[TB] FAIL sltiu_carry got %b want 0", bus.flag_carry); else passed++;
      drive_uop(OP_SLTI, 32'd5, 32'd0, 12'hFFF, 5'd7);
      tick();
      total++; if (bus.result !== 32'd0) $display("[TB] FAIL slti_result got %h want 0", bus.result); else passed++;
   endtask

   task automatic test_illegal();
      drive_uop(OP_RSVD, 32'd3, 32'd4, 12'h5, 5'd8);
      tick();
      total++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL ill_valid got %b want 1", bus.out_valid); else passed++;
      total++; if (bus.illegal !== 1'b1) $display("[TB] FAIL ill_flag got %b want 1", bus.illegal); else passed++;
      total++; if (bus.result !== 32'd0) $display("[TB] FAIL ill_result got %h want 0", bus.result); else passed++;
      total++; if ({bus.flag_zero, bus.flag_carry, bus.flag_ovf} !== 3'b000)
         $display("[TB] FAIL ill_flags got %b want 000", {bus.flag_zero, bus.flag_carry, bus.flag_ovf}); else passed++;
   endtask

   task automatic test_back_to_back();
      int sent = 0;
      int recv = 0;
      int cyc = 0;
      logic prev_hold = 1'b0;
      logic [DW-1:0] held_result = '0;
      logic [TW-1:0] held_tag = '0;
      tick();
      while (recv < 6 && cyc < 40) begin
         bus.out_ready = (cyc >= 4);
         bus.in_valid  = (sent < 6);
         bus.op = OP_ADD; bus.src1 = 32'(sent * 16); bus.src2 = 32'(sent); bus.imm = '0; bus.tag_in = TW'(sent);
         #1;
         if (prev_hold) begin
            total++; if (bus.result !== held_result || bus.tag_out !== held_tag)
               $display("[TB] FAIL b2b_stable got %h/%0d want %h/%0d", bus.result, bus.tag_out, held_result, held_tag); else passed++;
         end
         if (cyc == 3) begin
            total++; if (bus.in_ready !== 1'b0 || sent != 2)
               $display("[TB] FAIL b2b_backpressure got ready=%b accepts=%0d want ready=0 accepts=2", bus.in_ready, sent); else passed++;
         end
         if (bus.out_valid && bus.out_ready) begin
            total++; if (bus.tag_out !== TW'(recv) || bus.result !== 32'(recv * 17))
               $display("[TB] FAIL b2b_order got %h/%0d want %h/%0d", bus.result, bus.tag_out, 32'(recv * 17), recv); else passed++;
            recv++;
         end
         prev_hold   = bus.out_valid && !bus.out_ready;
         held_result = bus.result;
         held_tag    = bus.tag_out;
         if (bus.in_valid && bus.in_ready) sent++;
         tick();
         cyc++;
      end
      bus.in_valid = 1'b0;
      total++; if (recv != 6) $display("[TB] FAIL b2b_count got %0d want 6", recv); else passed++;
      tick();
      total++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL b2b_drained got %b want 0", bus.out_valid); else passed++;
   endtask

   task automatic test_flush();
      bus.out_ready = 1'b0;
      drive_uop(OP_ADD, 32'd1, 32'd2, '0, 5'd10);
      drive_uop(OP_ADD, 32'd3, 32'd4, '0, 5'd11);
      bus.flush = 1'b1;
      bus.op = OP_ADD; bus.src1 = 32'd7; bus.src2 = 32'd7; bus.tag_in = 5'd12;
      bus.in_valid = 1'b1;
      #1;
      total++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL flush_in_ready got %b want 0", bus.in_ready); else passed++;
      tick();
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      total++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL flush_out_valid got %b want 0", bus.out_valid); else passed++;
      bus.out_ready = 1'b1;
      drive_uop(OP_ADD, 32'd1, 32'd1, '0, 5'd3);
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd2 || bus.tag_out !== 5'd3)
         $display("[TB] FAIL flush_next got v=%b %h/%0d want v=1 2/3", bus.out_valid, bus.result, bus.tag_out); else passed++;
      tick();
      total++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL flush_no_ghost got %b want 0", bus.out_valid); else passed++;
   endtask

   task automatic test_async_reset();
      bus.out_ready = 1'b0;
      drive_uop(OP_ADD, 32'd2, 32'd2, '0, 5'd4);
      tick();
      total++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL arst_pre_valid got %b want 1", bus.out_valid); else passed++;
      #2;
      reset = 1'b0;
      #1;
      total++; if (bus.out_valid !== 1'b0 || bus.result !== 32'd0 || bus.tag_out !== 5'd0)
         $display("[TB] FAIL arst_outputs got v=%b %h/%0d want v=0 0/0", bus.out_valid, bus.result, bus.tag_out); else passed++;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      total++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL arst_in_ready got %b want 1", bus.in_ready); else passed++;
      bus.out_ready = 1'b1;
      drive_uop(OP_ADD, 32'd2, 32'd3, '0, 5'd7);
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd5 || bus.tag_out !== 5'd7)
         $display("[TB] FAIL arst_resume got v=%b %h/%0d want v=1 5/7", bus.out_valid, bus.result, bus.tag_out); else passed++;
   endtask

   initial begin
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = '0; bus.src1 = '0; bus.src2 = '0;
      bus.imm = '0; bus.tag_in = '0; bus.out_ready = 1'b0;
      test_reset();
      test_add_latency();
      test_sub_addi();
      test_compare();
      test_illegal();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
